// File: rtl/glb_bank_arbiter.sv
// Shares one GLB bank SRAM port among NUM_REQ valid/ready requesters and
// routes each read response back to its issuer after the fixed bank latency.
`timescale 1ns/1ps
module glb_bank_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned RD_LATENCY   = 3,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ*DATA_W-1:0]    req_bit_sel,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         bank_wr_en,
  output logic                         bank_rd_en,
  output logic [ADDR_W-1:0]            bank_addr,
  output logic [DATA_W-1:0]            bank_data_in,
  output logic [DATA_W-1:0]            bank_bit_sel,
  input  logic [DATA_W-1:0]            bank_data_out,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [DATA_W-1:0] sel_arr  [NUM_REQ];

  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  wait_cnt [NUM_REQ];

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic              starve_hit;
  logic [ID_W-1:0]   starve_idx;
  logic              rr_hit;
  logic [ID_W-1:0]   rr_sel;
  logic [ID_W-1:0]   rr_pos;
  int unsigned       rr_idx;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [ID_W-1:0]       pipe_id [RD_LATENCY];
  logic [DATA_W-1:0]     rsp_data_q;

  // Unpack the flat request buses into per-requester slices
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    assign sel_arr[g]  = req_bit_sel[g*DATA_W +: DATA_W];
  end

  // Grant selection: starvation guard, then host, then round-robin
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    rr_hit     = 1'b0;
    rr_sel     = '0;
    rr_pos     = '0;
    rr_idx     = 0;
    grant_vld  = 1'b0;
    grant_idx  = '0;

    // Descending scan so the lowest starving index wins
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (wait_cnt[i] == CNT_W'(STARVE_LIMIT))) begin
        starve_hit = 1'b1;
        starve_idx = ID_W'(i);
      end
    end

    // Descending offset so the first valid after rr_ptr wins
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      rr_idx = 32'(rr_ptr) + k;
      if (rr_idx >= NUM_REQ) begin
        rr_idx = rr_idx - NUM_REQ;
      end
      rr_pos = ID_W'(rr_idx);
      if (req_valid[rr_pos]) begin
        rr_hit = 1'b1;
        rr_sel = rr_pos;
      end
    end

    if (reset_n) begin
      if (starve_hit) begin
        grant_vld = 1'b1;
        grant_idx = starve_idx;
      end else if (req_valid[0]) begin
        grant_vld = 1'b1;
        grant_idx = '0;
      end else if (rr_hit) begin
        grant_vld = 1'b1;
        grant_idx = rr_sel;
      end
    end
  end

  // Bank port and ready mirror the granted request
  always_comb begin
    req_ready    = '0;
    grant_id     = '0;
    bank_wr_en   = 1'b0;
    bank_rd_en   = 1'b0;
    bank_addr    = '0;
    bank_data_in = '0;
    bank_bit_sel = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
      grant_id             = grant_idx;
      bank_wr_en           = req_wr[grant_idx];
      bank_rd_en           = !req_wr[grant_idx];
      bank_addr            = addr_arr[grant_idx];
      if (req_wr[grant_idx]) begin
        bank_data_in = data_arr[grant_idx];
        bank_bit_sel = sel_arr[grant_idx];
      end
    end
  end

  // Response steering from the last read-pipe stage
  always_comb begin
    rsp_valid = '0;
    rsp_data  = rsp_data_q;
    if (pipe_vld[RD_LATENCY-1]) begin
      rsp_valid[pipe_id[RD_LATENCY-1]] = 1'b1;
      rsp_data                         = bank_data_out;
    end
  end

  // Round-robin pointer and per-requester starvation counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      if (grant_vld) begin
        rr_ptr <= grant_idx;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || req_ready[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Read-return pipe carrying {vld,id}; reset drops in-flight reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld   <= '0;
      rsp_data_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_id[s] <= '0;
      end
    end else begin
      pipe_vld[0] <= grant_vld && !req_wr[grant_idx];
      pipe_id[0]  <= grant_idx;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
      if (pipe_vld[RD_LATENCY-1]) begin
        rsp_data_q <= bank_data_out;
      end
    end
  end

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// Directed bench for glb_bank_arbiter: grant/bank-port checks inline, read
// responses checked by a scoreboard monitor against a behavioural bank model.
`timescale 1ns/1ps
module tb_glb_bank_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned ADDR_W       = 17;
  localparam int unsigned DATA_W       = 64;
  localparam int unsigned RD_LATENCY   = 3;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef struct {
    int          id;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_wr;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ*DATA_W-1:0]  req_bit_sel;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [DATA_W-1:0]          rsp_data;
  logic                       bank_wr_en;
  logic                       bank_rd_en;
  logic [ADDR_W-1:0]          bank_addr;
  logic [DATA_W-1:0]          bank_data_in;
  logic [DATA_W-1:0]          bank_bit_sel;
  logic [DATA_W-1:0]          bank_data_out;
  logic [1:0]                 grant_id;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  int          gseq[$];
  logic [63:0] mem [logic [16:0]];
  logic [63:0] rd_pipe [RD_LATENCY];
  logic [3:0]  pend = '0;

  glb_bank_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .RD_LATENCY(RD_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_bit_sel(req_bit_sel),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_wr_en(bank_wr_en), .bank_rd_en(bank_rd_en), .bank_addr(bank_addr),
    .bank_data_in(bank_data_in), .bank_bit_sel(bank_bit_sel),
    .bank_data_out(bank_data_out), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten bank locations hold an address-derived pattern
  function automatic logic [63:0] dflt(input logic [16:0] a);
    return {32'hA5C30000 | 32'(a), 32'hFFFF0000 ^ 32'(a)};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [16:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  // Bank SRAM model with RD_LATENCY read latency and bit-masked writes
  always @(posedge clk) begin
    if (bank_wr_en)
      mem[bank_addr] = (mem_rd(bank_addr) & ~bank_bit_sel) | (bank_data_in & bank_bit_sel);
    rd_pipe[0] <= bank_rd_en ? mem_rd(bank_addr) : 64'h0;
    for (int s = 1; s < RD_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign bank_data_out = rd_pipe[RD_LATENCY-1];

  // Requesters must hold valid until ready
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      assert (!(reset_n && pend[i] && !req_valid[i]))
        else $error("protocol: requester %0d dropped valid before ready", i);
    pend <= reset_n ? (req_valid & ~req_ready) : 4'b0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_rd(input int r, input logic [63:0] d);
    exp_t e;
    e.id   = r;
    e.data = d;
    e.due  = cyc + int'(RD_LATENCY);
    sbq.push_back(e);
  endtask

  task automatic set_req(input int r, input logic wr, input logic [16:0] a,
                         input logic [63:0] d, input logic [63:0] bs);
    req_wr[r]                      = wr;
    req_addr[r*ADDR_W +: ADDR_W]   = a;
    req_data[r*DATA_W +: DATA_W]   = d;
    req_bit_sel[r*DATA_W +: DATA_W] = bs;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},    64'(req_ready),    64'h0);
    chk({tag, "_rsp_vld"},  64'(rsp_valid),    64'h0);
    chk({tag, "_rsp_data"}, rsp_data,          64'h0);
    chk({tag, "_gid"},      64'(grant_id),     64'h0);
    chk({tag, "_wr_en"},    64'(bank_wr_en),   64'h0);
    chk({tag, "_rd_en"},    64'(bank_rd_en),   64'h0);
    chk({tag, "_addr"},     64'(bank_addr),    64'h0);
    chk({tag, "_din"},      bank_data_in,      64'h0);
    chk({tag, "_bsel"},     bank_bit_sel,      64'h0);
  endtask

  // Hold vmask valid (reads of 0x200+r), checking the hand-computed grant
  // sequence in gseq; from step drop_from a requester leaves once granted.
  task automatic run_seq(input string tag, input logic [3:0] vmask, input int drop_from);
    logic [3:0] cur;
    int g;
    cur = vmask;
    for (int k = 0; k < gseq.size(); k++) begin
      @(posedge clk); #1;
      req_valid = cur;
      @(negedge clk);
      g = gseq[k];
      chk($sformatf("%s_k%0d_gid", tag, k), 64'(grant_id), 64'(g));
      chk($sformatf("%s_k%0d_ready", tag, k), 64'(req_ready), 64'(4'b0001 << g));
      push_rd(g, dflt(17'(32'h200 + g)));
      if (k >= drop_from) cur[g] = 1'b0;
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  // Scoreboard monitor: every response must match the oldest expected read
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding (cycle %0d)", rsp_valid, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id",      64'(rsp_valid), 64'(4'b0001 << mon_e.id));
        chk("rsp_data",    rsp_data,       mon_e.data);
        chk("rsp_latency", 64'(cyc),       64'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] wexp;
    req_valid   = '0;
    req_wr      = '0;
    req_addr    = '0;
    req_data    = '0;
    req_bit_sel = '0;
    reset_n     = 1'b0;

    repeat (2) @(negedge clk);
    chk_idle("rst");
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");

    // T2: single read by requester 2
    @(posedge clk); #1;
    set_req(2, 1'b0, 17'h40, 64'h1234_5678_9ABC_DEF0, '1);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t2_gid",   64'(grant_id),   64'd2);
    chk("t2_ready", 64'(req_ready),  64'b0100);
    chk("t2_rd_en", 64'(bank_rd_en), 64'd1);
    chk("t2_wr_en", 64'(bank_wr_en), 64'd0);
    chk("t2_addr",  64'(bank_addr),  64'h40);
    chk("t2_din",   bank_data_in,    64'h0);
    chk("t2_bsel",  bank_bit_sel,    64'h0);
    push_rd(2, dflt(17'h40));
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("t2_rsp_off",  64'(rsp_valid), 64'h0);
    chk("t2_rsp_hold", rsp_data,       dflt(17'h40));

    // T1: reset two cycles after a read grant drops the read
    @(posedge clk); #1;
    set_req(1, 1'b0, 17'h10, 64'h0, 64'h0);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t1_gid", 64'(grant_id), 64'd1);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk_idle("t1_in_rst");
    @(negedge clk);
    chk("t1_no_rsp", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk_idle("t1_post");

    // T3: round-robin among 1..3 from reset pointer
    for (int r = 1; r < 4; r++) set_req(r, 1'b0, 17'(32'h200 + r), 64'h0, 64'h0);
    gseq = {1, 2, 3, 1, 2, 3, 1, 2, 3};
    run_seq("t3", 4'b1110, 6);

    // T4: host always valid, requester 3 rescued by starvation guard
    set_req(0, 1'b0, 17'h200, 64'h0, 64'h0);
    gseq = {0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 0};
    run_seq("t4", 4'b1001, 9);

    // T5: back-to-back alternating reads
    for (int k = 0; k < 6; k++) begin
      int r;
      r = (k % 2 == 0) ? 1 : 2;
      @(posedge clk); #1;
      set_req(r, 1'b0, 17'(32'h300 + k), 64'h0, 64'h0);
      req_valid = 4'(1 << r);
      @(negedge clk);
      chk($sformatf("t5_k%0d_gid", k), 64'(grant_id), 64'(r));
      push_rd(r, dflt(17'(32'h300 + k)));
    end
    @(posedge clk); #1 req_valid = '0;

    // T6: masked write then read-back
    @(posedge clk); #1;
    set_req(3, 1'b1, 17'h1F, 64'hDEAD, 64'hFFFF);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("t6_gid",   64'(grant_id),   64'd3);
    chk("t6_wr_en", 64'(bank_wr_en), 64'd1);
    chk("t6_rd_en", 64'(bank_rd_en), 64'd0);
    chk("t6_addr",  64'(bank_addr),  64'h1F);
    chk("t6_din",   bank_data_in,    64'hDEAD);
    chk("t6_bsel",  bank_bit_sel,    64'hFFFF);
    @(posedge clk); #1;
    set_req(3, 1'b0, 17'h1F, 64'h0, 64'h0);
    @(negedge clk);
    chk("t6_rd_en2", 64'(bank_rd_en), 64'd1);
    wexp = dflt(17'h1F);
    wexp = {wexp[63:16], 16'hDEAD};
    push_rd(3, wexp);
    @(posedge clk); #1 req_valid = '0;

    repeat (8) @(negedge clk);
    chk("sb_drain", 64'(sbq.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
